image_pass_sequencer: RTL and testbench
=======================================

Name: image_pass_sequencer

Overview:
- Sequences one full-frame 3x3 filter pass over the image container.
- Per output row r: issues one 3-row read (rows r-1, r, r+1, edge-clamped) on the container's three read ports, then waits for the filter unit's result and writes that row into the selected destination bank.
- Also owns the container write port for the host: host writes pass through while idle and are stalled while a pass runs.

Parameters:
- ROWS, 128, rows per image bank; max rows per pass.
- ROW_AW, 7, row address width (log2 ROWS).
- DATA_W, 3072, row data width in bits.
- TIMEOUT_CYC, 255, filter-response watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pass request
- num_rows  in  8  rows to process; 0 = empty pass, values > ROWS clamp to ROWS
- dst_bank  in  2  destination bank 0..2; 3 is illegal
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass end
- err  out  1  one-cycle pulse on rejected start or timeout abort
- re  out  1  container read enable
- raddr0  out  ROW_AW  upper row (r-1, clamped)
- raddr1  out  ROW_AW  centre row (r)
- raddr2  out  ROW_AW  lower row (r+1, clamped)
- we  out  1  container write enable
- waddr  out  ROW_AW+2  {bank, row} write address
- wdata  out  DATA_W  container write data
- filt_valid  in  1  filter result valid
- filt_data  in  DATA_W  filter result row
- host_we  in  1  host write request
- host_waddr  in  ROW_AW+2  host write address
- host_wdata  in  DATA_W  host write data
- host_stall  out  1  host write not accepted this cycle

Behaviour:
- Reset: busy, done, err, re, we = 0; raddr0/1/2 = 0; waddr = 0; wdata = 0; host_stall = 0; FSM = IDLE; row counter = 0.
- All container-side outputs (re, raddrN, we, waddr, wdata) are registered.
- IDLE:
  - A start with dst_bank = 3 is rejected: err pulses the next cycle; no accesses are issued; FSM stays in IDLE.
  - A start with num_rows = 0 goes to DONE with no accesses.
  - Otherwise: latch num_rows (clamped to ROWS), dst_bank, row = 0; go to READ.
  - While idle, host writes pass through with 1-cycle latency: we = host_we, waddr = host_waddr, wdata = host_wdata.
- READ (1 cycle):
  - re = 1; raddr1 = row.
  - raddr0 = (row == 0) ? 0 : row-1.
  - raddr2 = (row == last) ? row : row+1, where last = num_rows-1.
  - Next state: WAIT.
- WAIT:
  - re = 0; hold in WAIT until filt_valid = 1.
  - On filt_valid, capture filt_data; go to WRITE.
  - filt_valid while not in WAIT is ignored.
- WRITE (1 cycle):
  - we = 1; waddr = {dst_bank, row}; wdata = captured row.
  - If row == last, go to DONE; else row++ and go to READ.
  - Row spacing is READ + WAIT (at least 1 cycle) + WRITE, so at least 3 cycles per row.
- DONE (1 cycle): done = 1; go to IDLE.
- busy = 1 in every state except IDLE.
- host_stall = busy. Host writes issued while busy are dropped; the host must hold the request until host_stall = 0.
- A start arriving while busy is ignored (no err).
- start and host_we in the same IDLE cycle: start wins, the host write is dropped, and host_stall = 1 from the next cycle.
- Reset asserted mid-pass: the pass is abandoned immediately, all outputs take reset values, and no done pulse is generated.
- Single-row pass: raddr0 = raddr1 = raddr2 = 0.

Optional Feature:
- Macro: IMAGE_PASS_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in WAIT and clears on entry to WAIT.
  - If TIMEOUT_CYC cycles pass without filt_valid, the pass aborts: err pulses, no write is issued for that row, no done pulse, FSM returns to IDLE.
- Undefined:
  - WAIT holds indefinitely.
  - err is asserted only for an illegal dst_bank.

Test Plan:
- Idle host write: host_we = 1, host_waddr = 9'h081, host_wdata = all-ones -> next cycle we = 1, waddr = 9'h081, wdata = all-ones; host_stall = 0.
- 4-row pass: start, num_rows = 4, dst_bank = 2, filter returns 2 cycles after each re ->
  - reads (0,0,1), (0,1,2), (1,2,3), (2,3,3);
  - writes to waddr 9'h100..9'h103 with matching filt_data;
  - one done pulse; busy deasserts the cycle after done.
- Host write attempted mid-pass -> host_stall = 1, no we except sequencer writes; after done, the retried host write lands.
- Boundary starts:
  - start with dst_bank = 3 -> err pulse, busy stays 0.
  - start with num_rows = 0 -> done pulse, no re/we.
  - num_rows = 200 -> 128 rows written, last read (126,127,127).
- start held high during a pass, and filt_valid injected outside WAIT -> both ignored; row count and data unaffected.
- With IMAGE_PASS_SEQ_TIMEOUT_EN: filt_valid withheld after row 1 read -> err after 255 cycles, no write to row 1, busy = 0, no done. Also assert rst_n low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/image_pass_sequencer.sv
// image_pass_sequencer
//   Runs one full-frame 3x3 filter pass over the image container. For each
//   output row it issues one 3-row read (r-1, r, r+1 with edge clamping), waits
//   for the filter result, then writes that row into the destination bank.
//   It also owns the container write port. Host writes pass through while the
//   sequencer is idle and are stalled while a pass runs.
//
//   Optional feature: define IMAGE_PASS_SEQ_TIMEOUT_EN to enable the
//   filter-response watchdog. The pass aborts after TIMEOUT_CYC cycles in WAIT.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start, num_rows, dst_bank  pass request, row count (0 = empty, >ROWS clamps), bank 0..2
//   busy, done, err            status; done/err are one-cycle pulses
//   re, raddr0/1/2             registered container read (upper/centre/lower row)
//   we, waddr, wdata           registered container write ({bank,row} address)
//   filt_valid, filt_data      filter result handshake
//   host_we/waddr/wdata        host write request
//   host_stall                 host write not accepted this cycle
//
// state   | meaning
// S_IDLE  | no pass; host writes pass through
// S_READ  | re asserted for the current row's three source rows
// S_WAIT  | waiting for filt_valid
// S_WRITE | we asserted with the captured filter row
// S_DONE  | done pulse, then back to idle
module image_pass_sequencer #(
  parameter int ROWS        = 128,
  parameter int ROW_AW      = 7,
  parameter int DATA_W      = 3072,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          num_rows,
  input  logic [1:0]          dst_bank,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                re,
  output logic [ROW_AW-1:0]   raddr0,
  output logic [ROW_AW-1:0]   raddr1,
  output logic [ROW_AW-1:0]   raddr2,
  output logic                we,
  output logic [ROW_AW+1:0]   waddr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                filt_valid,
  input  logic [DATA_W-1:0]   filt_data,
  input  logic                host_we,
  input  logic [ROW_AW+1:0]   host_waddr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                host_stall
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  localparam logic [ROW_AW-1:0] ROW_ONE = ROW_AW'(1);

  state_t            state, state_nxt;
  logic [ROW_AW-1:0] row, row_nxt;
  logic [ROW_AW-1:0] last, last_nxt;
  logic [ROW_AW-1:0] last_in;
  logic [ROW_AW-1:0] rd_upper, rd_lower;
  logic [7:0]        nr_m1;
  logic [1:0]        bank;
  logic              accept, reject, timeout;

  assign accept = (state == S_IDLE) && start && (dst_bank != 2'd3);
  assign reject = (state == S_IDLE) && start && (dst_bank == 2'd3);

  // Index of the last row of the pass; counts above ROWS clamp to ROWS.
  assign nr_m1   = num_rows - 8'd1;
  assign last_in = (num_rows > 8'(ROWS)) ? ROW_AW'(ROWS - 1) : ROW_AW'(nr_m1);

`ifdef IMAGE_PASS_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= 8'd0;
    else if (state == S_READ)   wait_cnt <= 8'd0;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + 8'd1;
  end

  // Fires in the last of TIMEOUT_CYC silent WAIT cycles.
  assign timeout = (state == S_WAIT) && !filt_valid && (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    last_nxt  = last;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (num_rows == 8'd0) ? S_DONE : S_READ;
          row_nxt   = '0;
          last_nxt  = last_in;
        end
      end
      S_READ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (filt_valid)   state_nxt = S_WRITE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_WRITE: begin
        if (row == last) state_nxt = S_DONE;
        else begin
          state_nxt = S_READ;
          row_nxt   = row + ROW_ONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read addresses are computed for the row about to enter READ so the
  // registered outputs line up with the READ state.
  assign rd_upper = (row_nxt == '0) ? '0 : row_nxt - ROW_ONE;
  assign rd_lower = (row_nxt == last_nxt) ? row_nxt : row_nxt + ROW_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      row    <= '0;
      last   <= '0;
      bank   <= '0;
      err    <= 1'b0;
      re     <= 1'b0;
      raddr0 <= '0;
      raddr1 <= '0;
      raddr2 <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      last  <= last_nxt;
      if (accept) bank <= dst_bank;
      err <= reject || timeout;
      re  <= (state_nxt == S_READ);
      if (state_nxt == S_READ) begin
        raddr0 <= rd_upper;
        raddr1 <= row_nxt;
        raddr2 <= rd_lower;
      end
      we <= 1'b0;
      if ((state == S_IDLE) && !start) begin
        // Any start in the same cycle wins over the host write.
        we    <= host_we;
        waddr <= host_waddr;
        wdata <= host_wdata;
      end else if ((state == S_WAIT) && filt_valid) begin
        // wdata doubles as the capture register for the filter row.
        we    <= 1'b1;
        waddr <= {bank, row};
        wdata <= filt_data;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign host_stall = busy;

endmodule

// File: tb/tb_image_pass_sequencer.sv
module tb_image_pass_sequencer;
  localparam int ROWS   = 128;
  localparam int ROW_AW = 7;
  localparam int DATA_W = 3072;
  localparam int REP    = DATA_W / 32;

  logic clk, rst_n, start;
  logic [7:0] num_rows;
  logic [1:0] dst_bank;
  logic busy, done, err, re, we, filt_valid, host_we, host_stall;
  logic [ROW_AW-1:0] raddr0, raddr1, raddr2;
  logic [ROW_AW+1:0] waddr, host_waddr;
  logic [DATA_W-1:0] wdata, filt_data, host_wdata;

  image_pass_sequencer #(.ROWS(ROWS), .ROW_AW(ROW_AW), .DATA_W(DATA_W), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .dst_bank(dst_bank),
    .busy(busy), .done(done), .err(err), .re(re), .raddr0(raddr0), .raddr1(raddr1),
    .raddr2(raddr2), .we(we), .waddr(waddr), .wdata(wdata), .filt_valid(filt_valid),
    .filt_data(filt_data), .host_we(host_we), .host_waddr(host_waddr),
    .host_wdata(host_wdata), .host_stall(host_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int r);
    return 32'hC0DE_0000 | 32'(r);
  endfunction

  // ---------------- monitor ----------------
  typedef struct {
    logic [ROW_AW+1:0] a;
    logic [31:0]       lo;
    logic [31:0]       hi;
  } wr_t;

  logic [3*ROW_AW-1:0] rd_q[$];
  wr_t                 wr_q[$];
  int                  done_cnt = 0;
  int                  err_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (re) rd_q.push_back({raddr0, raddr1, raddr2});
      if (we) wr_q.push_back('{waddr, wdata[31:0], wdata[DATA_W-1 -: 32]});
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  // ---------------- filter responder ----------------
  // Returns the row 2 cycles after re. With inject set, also drives junk
  // filt_valid during READ and WRITE, which the sequencer must ignore.
  bit inject = 0;
  bit withhold = 0;
  int dly = 0;
  int prow = 0;

  initial begin
    filt_valid = 1'b0;
    filt_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      filt_valid = 1'b0;
      if (re) begin
        prow = int'(raddr1);
        dly  = (withhold && raddr1 == 7'd1) ? 0 : 2;
        if (inject) begin filt_valid = 1'b1; filt_data = {REP{32'hBAD0_BAD0}}; end
      end else if (dly == 2) begin
        dly = 1;
      end else if (dly == 1) begin
        dly = 0;
        filt_valid = 1'b1;
        filt_data  = {REP{pat(prow)}};
      end else if (inject && we) begin
        filt_valid = 1'b1;
        filt_data  = {REP{32'hDEAD_BEEF}};
      end
    end
  end

  // ---------------- pass driver ----------------
  task automatic clear_log();
    rd_q.delete();
    wr_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic run_pass(input int nr, input int bank, input int hold, input int budget,
                          output bit finished, output logic busy_after);
    int n;
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; num_rows = 8'(nr); dst_bank = 2'(bank);
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    finished = 1'b0;
    n = 0;
    while (!finished && n < budget) begin
      @(negedge clk);
      n++;
      if (n >= hold) start = 1'b0;
      if (done || err) finished = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                  nr;
    int                  bank;
    int                  hold;
    bit                  inj;
    int                  exp_n;
    int                  exp_done;
    int                  exp_err;
    logic [3*ROW_AW-1:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit finished;
    logic busy_after;
    int n, bad, last, cnt, nseq;
    string nm;

    vecs[0] = '{4,   2, 0, 0, 4,   1, 0, {7'd2,   7'd3,   7'd3}};
    vecs[1] = '{1,   0, 0, 0, 1,   1, 0, {7'd0,   7'd0,   7'd0}};
    vecs[2] = '{0,   1, 0, 0, 0,   1, 0, 21'd0};
    vecs[3] = '{3,   3, 0, 0, 0,   0, 1, 21'd0};
    vecs[4] = '{200, 1, 0, 0, 128, 1, 0, {7'd126, 7'd127, 7'd127}};
    vecs[5] = '{3,   0, 6, 1, 3,   1, 0, {7'd1,   7'd2,   7'd2}};
    vecs[6] = '{2,   2, 0, 0, 2,   1, 0, {7'd0,   7'd1,   7'd1}};

    rst_n = 1'b0; start = 1'b0; num_rows = '0; dst_bank = '0;
    host_we = 1'b0; host_waddr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, err, re, we, host_stall}, 0);
    chk("rst_raddr", {raddr0, raddr1, raddr2}, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", (wdata == '0), 1);
    rst_n = 1'b1;

    // Idle host write passes through with one cycle of latency.
    @(posedge clk); #1;
    host_we = 1'b1; host_waddr = 9'h081; host_wdata = '1;
    @(posedge clk); #1;
    host_we = 1'b0;
    chk("host_idle_we", we, 1);
    chk("host_idle_waddr", waddr, 9'h081);
    chk("host_idle_wdata", (wdata == {DATA_W{1'b1}}), 1);
    chk("host_idle_stall", host_stall, 0);
    repeat (2) @(negedge clk);

    // Table-driven passes, checked against an edge-clamp model.
    for (int v = 0; v < 7; v++) begin
      inject = vecs[v].inj;
      run_pass(vecs[v].nr, vecs[v].bank, vecs[v].hold, 2000, finished, busy_after);
      inject = 0;
      nm = $sformatf("v%0d", v);
      chk({nm, "_finished"}, finished, 1);
      chk({nm, "_done_cnt"}, done_cnt, vecs[v].exp_done);
      chk({nm, "_err_cnt"}, err_cnt, vecs[v].exp_err);
      chk({nm, "_n_reads"}, rd_q.size(), vecs[v].exp_n);
      chk({nm, "_n_writes"}, wr_q.size(), vecs[v].exp_n);
      chk({nm, "_busy_after"}, busy_after, 0);
      if (vecs[v].exp_n > 0)
        chk({nm, "_last_read"}, rd_q[rd_q.size()-1], vecs[v].exp_last);
      last = (vecs[v].nr > ROWS ? ROWS : vecs[v].nr) - 1;
      bad = 0;
      foreach (rd_q[i])
        if (rd_q[i] !== {7'(i == 0 ? 0 : i - 1), 7'(i), 7'(i == last ? i : i + 1)}) bad++;
      foreach (wr_q[i])
        if (wr_q[i].a !== {2'(vecs[v].bank), 7'(i)} || wr_q[i].lo !== pat(i) || wr_q[i].hi !== pat(i)) bad++;
      chk({nm, "_model"}, bad, 0);
    end

    // Host write during a pass: stalled, dropped, and lands after done.
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; num_rows = 8'd4; dst_bank = 2'd2;
    host_we = 1'b1; host_waddr = 9'h0AA; host_wdata = {REP{32'h5555_5555}};
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_host_stall", host_stall, 1);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("mid_done_seen", done, 1);
    cnt = 0; nseq = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].a == 9'h0AA) cnt++;
      else if (wr_q[i].a[8:7] == 2'd2) nseq++;
    end
    chk("mid_host_dropped", cnt, 0);
    chk("mid_seq_writes", nseq, 4);
    repeat (2) @(negedge clk);
    chk("mid_host_retry_we", we, 1);
    chk("mid_host_retry_addr", waddr, 9'h0AA);
    chk("mid_host_retry_data", wdata[63:0], 64'h5555_5555_5555_5555);
    host_we = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the WAIT of row 1: everything clears at once, no done.
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; num_rows = 8'd4; dst_bank = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(re && raddr1 == 7'd1) && n < 100) begin @(negedge clk); n++; end
    chk("rstmid_reached_row1", {re, raddr0, raddr1, raddr2}, {1'b1, 7'd0, 7'd1, 7'd2});
    @(negedge clk);
    chk("rstmid_pre_waddr", waddr, 9'h100);
    rst_n = 1'b0;
    #1;
    chk("rstmid_status", {busy, done, err, re, we, host_stall}, 0);
    chk("rstmid_addrs", {raddr0, raddr1, raddr2, waddr}, 0);
    chk("rstmid_wdata", (wdata == '0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", done_cnt, 0);
    chk("rstmid_idle", busy, 0);

`ifdef IMAGE_PASS_SEQ_TIMEOUT_EN
    // Filter never answers row 1: abort after 255 WAIT cycles.
    clear_log();
    withhold = 1;
    @(posedge clk); #1;
    start = 1'b1; num_rows = 8'd3; dst_bank = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(re && raddr1 == 7'd1) && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!err && n < 400) begin @(negedge clk); n++; end
    withhold = 0;
    chk("to_err_delay", n, 256);
    @(negedge clk);
    chk("to_busy", busy, 0);
    cnt = 0;
    foreach (wr_q[i]) if (wr_q[i].a == 9'h081) cnt++;
    chk("to_no_row1_write", cnt, 0);
    chk("to_no_done", done_cnt, 0);
    chk("to_err_cnt", err_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
